// File: rtl/lvl_state_writer.sv
// Write side of the level-states BRAM: records a bin at each new global level and
// clears entries above a backtrack target, one per cycle, while holding the BRAM mux.
//
// state | meaning
// IDLE  | waiting for a request; drops busy the cycle after done
// PUSH  | one write of {bin, 0} at the next level, or overflow
// CLEAR | zero-writes descending from cur_lvl_o down to target+1
// DONE  | emits done_o (and err_o) for one cycle
module lvl_state_writer #(
  parameter int WIDTH_LVL             = 16,
  parameter int WIDTH_BIN_ID          = 10,
  parameter int WIDTH_LVL_STATES      = 11,
  parameter int ADDR_WIDTH_LVL_STATES = 9,
  parameter int MAX_LVL               = 511
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_i,
  input  logic [WIDTH_BIN_ID-1:0]          push_bin_i,
  input  logic                             trunc_i,
  input  logic [WIDTH_LVL-1:0]             trunc_lvl_i,
  output logic                             busy_o,
  output logic                             apply_wr_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [WIDTH_LVL-1:0]             cur_lvl_o,
  output logic                             ram_we_ls_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0] ram_waddr_ls_o,
  output logic [WIDTH_LVL_STATES-1:0]      ram_wdata_ls_o
);

  typedef enum logic [1:0] {IDLE, PUSH, CLEAR, DONE} state_t;

  localparam logic [WIDTH_LVL-1:0] MAX_L = WIDTH_LVL'(MAX_LVL);

  state_t                  state;
  logic [WIDTH_BIN_ID-1:0] bin_q;
  logic [WIDTH_LVL-1:0]    tgt_q;
  logic [WIDTH_LVL-1:0]    cnt;
  logic [WIDTH_LVL-1:0]    cnt_dec;
  logic                    err_q;

  assign cnt_dec = cnt - WIDTH_LVL'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      bin_q          <= '0;
      tgt_q          <= '0;
      cnt            <= '0;
      err_q          <= 1'b0;
      busy_o         <= 1'b0;
      apply_wr_o     <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      cur_lvl_o      <= '0;
      ram_we_ls_o    <= 1'b0;
      ram_waddr_ls_o <= '0;
      ram_wdata_ls_o <= '0;
    end else begin
      ram_we_ls_o    <= 1'b0;
      ram_waddr_ls_o <= '0;
      ram_wdata_ls_o <= '0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      case (state)
        IDLE: begin
          busy_o     <= 1'b0;
          apply_wr_o <= 1'b0;
          err_q      <= 1'b0;
          // busy_o is still high during the done cycle, so requests there are dropped
          if (!busy_o && trunc_i) begin
            tgt_q      <= trunc_lvl_i;
            cnt        <= cur_lvl_o;
            busy_o     <= 1'b1;
            apply_wr_o <= 1'b1;
            state      <= CLEAR;
          end else if (!busy_o && push_i) begin
            bin_q      <= push_bin_i;
            busy_o     <= 1'b1;
            apply_wr_o <= 1'b1;
            state      <= PUSH;
          end
        end
        PUSH: begin
          if (cur_lvl_o < MAX_L) begin
            ram_we_ls_o    <= 1'b1;
            ram_waddr_ls_o <= cur_lvl_o[ADDR_WIDTH_LVL_STATES-1:0];
            ram_wdata_ls_o <= {bin_q, 1'b0};
            cur_lvl_o      <= cur_lvl_o + WIDTH_LVL'(1);
          end else begin
            err_q <= 1'b1;
          end
          state <= DONE;
        end
        CLEAR: begin
          if (cnt > tgt_q) begin
            ram_we_ls_o    <= 1'b1;
            ram_waddr_ls_o <= cnt_dec[ADDR_WIDTH_LVL_STATES-1:0];
            cnt            <= cnt_dec;
            if (cnt_dec == tgt_q) begin
              cur_lvl_o <= tgt_q;
              state     <= DONE;
            end
          end else begin
            err_q <= (tgt_q > cnt);
            state <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          err_o  <= err_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvl_state_writer.sv
// Directed bench for lvl_state_writer: a level model predicts BRAM writes into a
// scoreboard queue; a negedge monitor pops and compares every observed write.
module tb_lvl_state_writer;
  localparam int MAX_LVL = 511;

  logic        clk;
  logic        rst;
  logic        push_i;
  logic [9:0]  push_bin_i;
  logic        trunc_i;
  logic [15:0] trunc_lvl_i;
  logic        busy_o;
  logic        apply_wr_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] cur_lvl_o;
  logic        ram_we_ls_o;
  logic [8:0]  ram_waddr_ls_o;
  logic [10:0] ram_wdata_ls_o;

  int total = 0;
  int bad   = 0;
  int mcur  = 0;
  logic [19:0] sb[$];

  lvl_state_writer dut (
    .clk(clk), .rst(rst),
    .push_i(push_i), .push_bin_i(push_bin_i),
    .trunc_i(trunc_i), .trunc_lvl_i(trunc_lvl_i),
    .busy_o(busy_o), .apply_wr_o(apply_wr_o),
    .done_o(done_o), .err_o(err_o), .cur_lvl_o(cur_lvl_o),
    .ram_we_ls_o(ram_we_ls_o), .ram_waddr_ls_o(ram_waddr_ls_o),
    .ram_wdata_ls_o(ram_wdata_ls_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we_ls_o !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_we", {31'd0, ram_we_ls_o}, 32'd0);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        check("wr_addr", {23'd0, ram_waddr_ls_o}, {23'd0, e[19:11]});
        check("wr_data", {21'd0, ram_wdata_ls_o}, {21'd0, e[10:0]});
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_apply"}, {31'd0, apply_wr_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_we"}, {31'd0, ram_we_ls_o}, 32'd0);
    check({tag, "_waddr"}, {23'd0, ram_waddr_ls_o}, 32'd0);
    check({tag, "_wdata"}, {21'd0, ram_wdata_ls_o}, 32'd0);
    check({tag, "_cur"}, {16'd0, cur_lvl_o}, mcur);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic do_req(input bit p, input bit t, input logic [9:0] bin,
                        input logic [15:0] lvl, input bit hold_push);
    int exp_k;
    bit exp_err;
    int k;
    exp_k = 2;
    exp_err = 1'b0;
    if (t) begin
      if (int'(lvl) < mcur) begin
        for (int l = mcur; l > int'(lvl); l--) sb.push_back({9'(l - 1), 11'd0});
        exp_k = mcur - int'(lvl) + 1;
        mcur = int'(lvl);
      end else if (int'(lvl) > mcur) begin
        exp_err = 1'b1;
      end
    end else if (p) begin
      if (mcur < MAX_LVL) begin
        sb.push_back({9'(mcur), bin, 1'b0});
        mcur++;
      end else begin
        exp_err = 1'b1;
      end
    end
    push_i = p; trunc_i = t; push_bin_i = bin; trunc_lvl_i = lvl;
    @(posedge clk); #1;
    push_i = hold_push; trunc_i = 1'b0;
    if (hold_push) push_bin_i = 10'h3FF;
    k = 0;
    while (k < 700) begin
      @(negedge clk);
      if (k == 0) begin
        check("busy_start", {31'd0, busy_o}, 32'd1);
        check("apply_start", {31'd0, apply_wr_o}, 32'd1);
      end
      if (done_o === 1'b1) break;
      @(posedge clk);
      k++;
    end
    push_i = 1'b0;
    if (k >= 700) check("done_timeout", {31'd0, done_o}, 32'd1);
    check("done_latency", k, exp_k);
    check("err", {31'd0, err_o}, {31'd0, exp_err});
    check("busy_in_done", {31'd0, busy_o}, 32'd1);
    check("cur_lvl", {16'd0, cur_lvl_o}, mcur);
    check("sb_empty", sb.size(), 32'd0);
    @(negedge clk);
    check_idle_outputs("after_done");
  endtask

  initial begin
    rst = 1'b0; push_i = 1'b0; trunc_i = 1'b0; push_bin_i = '0; trunc_lvl_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    // push bin 5: write addr 0, data 0x00A
    do_req(1, 0, 10'd5, 16'd0, 0);
    // back to level 0, then push 3,7,9 and truncate to 1
    do_req(0, 1, 10'd0, 16'd0, 0);
    do_req(1, 0, 10'd3, 16'd0, 0);
    do_req(1, 0, 10'd7, 16'd0, 0);
    do_req(1, 0, 10'd9, 16'd0, 0);
    do_req(0, 1, 10'd0, 16'd1, 0);
    // push and trunc together with C=2, T=0: trunc wins
    do_req(1, 0, 10'd21, 16'd0, 0);
    do_req(1, 1, 10'd99, 16'd0, 0);
    // push held during a 4-entry clear is ignored
    for (int i = 0; i < 4; i++) do_req(1, 0, 10'(40 + i), 16'd0, 0);
    do_req(0, 1, 10'd0, 16'd0, 1);
    // T > C and T == C
    do_req(1, 0, 10'd11, 16'd0, 0);
    do_req(1, 0, 10'd12, 16'd0, 0);
    do_req(0, 1, 10'd0, 16'd4, 0);
    do_req(0, 1, 10'd0, 16'd2, 0);

    // reset during the 2nd write of a 4-entry clear
    do_req(1, 0, 10'd13, 16'd0, 0);
    do_req(1, 0, 10'd14, 16'd0, 0);
    sb.push_back({9'd3, 11'd0});
    sb.push_back({9'd2, 11'd0});
    trunc_i = 1'b1; trunc_lvl_i = 16'd0;
    @(posedge clk); #1;
    trunc_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    mcur = 0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    check("mid_reset_sb", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    check_idle_outputs("held_reset");
    rst = 1'b1;
    @(negedge clk);

    // fill to MAX_LVL, then overflow
    for (int i = 0; i < MAX_LVL; i++) do_req(1, 0, 10'(i), 16'd0, 0);
    check("preload_cur", {16'd0, cur_lvl_o}, 32'd511);
    do_req(1, 0, 10'd77, 16'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
